// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_WAIT = 2'd1,
    ARB_LS_WAIT = 2'd2,
    ARB_IF_DROP = 2'd3
  } arb_state_e;

  localparam int ARB_MAX_WAIT_DEF   = 255;
  localparam int ARB_STARVE_LIM_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait watchdog: counts enabled cycles since the last clear and saturates at
// MAX_WAIT. o_expired is high while the count sits at MAX_WAIT.
module arb_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up to the limit and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CW'(MAX_WAIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and
// load/store (LS). LS wins by default; IF is forced through after STARVE_LIM
// consecutive LS grants taken while IF was waiting. A watchdog ends any access
// that sees no ack within MAX_WAIT cycles, and a redirect (i_flush) during an
// IF access lets the memory finish but discards its response.
// Handshake: a requester holds req and fields stable until its one-cycle gnt;
// o_mem_req is held with stable fields until the cycle i_mem_ack is seen.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT   = ARB_MAX_WAIT_DEF,
  parameter int STARVE_LIM = ARB_STARVE_LIM_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_flush,
  output logic        o_if_gnt,
  output logic        o_if_rvld,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_wren,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvld,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wren_q, mem_wren_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_bmask_q, mem_bmask_d;
  logic          if_gnt_q, if_gnt_d;
  logic          ls_gnt_q, ls_gnt_d;
  logic          if_rvld_q, if_rvld_d;
  logic          ls_rvld_q, ls_rvld_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          err_q, err_d;

  logic if_win, ls_win;
  logic timer_clr, timer_en, timer_expired;

  // Watchdog runs in every busy state and restarts on each new grant.
  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (timer_clr),
    .i_enable  (timer_en),
    .o_expired (timer_expired)
  );

  // Arbitration decision; only acted on in IDLE. A redirect makes IF ineligible.
  always_comb begin
    if_win = i_if_req && !i_flush && (!i_ls_req || (starve_q == SW'(STARVE_LIM)));
    ls_win = i_ls_req && !if_win;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvld_d   = 1'b0;
    ls_rvld_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    err_d       = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = (state_q != ARB_IDLE) && !i_mem_ack;
    case (state_q)
      ARB_IDLE: begin
        if (ls_win) begin
          state_d     = ARB_LS_WAIT;
          mem_req_d   = 1'b1;
          mem_wren_d  = i_ls_wren;
          mem_addr_d  = i_ls_addr;
          mem_wdata_d = i_ls_wdata;
          mem_bmask_d = i_ls_bmask;
          ls_gnt_d    = 1'b1;
          timer_clr   = 1'b1;
          if (i_if_req && (starve_q != SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_win) begin
          state_d     = ARB_IF_WAIT;
          mem_req_d   = 1'b1;
          mem_wren_d  = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_bmask_d = 4'hF;
          if_gnt_d    = 1'b1;
          timer_clr   = 1'b1;
          starve_d    = '0;
        end
      end
      ARB_IF_WAIT: begin
        if (i_flush) begin
          // A redirect beats a same-cycle ack: the access is over but dropped.
          if (i_mem_ack) begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = ARB_IF_DROP;
          end
        end else if (i_mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          if_rvld_d  = 1'b1;
          if_rdata_d = i_mem_rdata;
        end else if (timer_expired) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          if_rvld_d  = 1'b1;
          if_rdata_d = '0;
          err_d      = 1'b1;
        end
      end
      ARB_LS_WAIT: begin
        if (i_mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          ls_rvld_d  = 1'b1;
          ls_rdata_d = mem_wren_q ? 32'd0 : i_mem_rdata;
        end else if (timer_expired) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          ls_rvld_d  = 1'b1;
          ls_rdata_d = '0;
          err_d      = 1'b1;
        end
      end
      ARB_IF_DROP: begin
        if (i_mem_ack || timer_expired) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvld_q   <= 1'b0;
      ls_rvld_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvld_q   <= if_rvld_d;
      ls_rvld_q   <= ls_rvld_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_if_gnt    = if_gnt_q;
  assign o_if_rvld   = if_rvld_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_gnt    = ls_gnt_q;
  assign o_ls_rvld   = ls_rvld_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and responses are queued
// as stimulus is issued; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 255;

  logic        clk;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_flush;
  logic        o_if_gnt, o_if_rvld;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_wren;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt, o_ls_rvld;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_wren;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_err, o_busy;

  // Memory model controls.
  int          mem_lat;
  logic        mem_never;
  logic [31:0] mem_data;
  int          mem_cnt;

  // Scoreboard: {is_ls, err, rdata} per response; 1 = LS for grants.
  logic [33:0] exp_q[$];
  logic        exp_gnt_q[$];
  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIM(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_flush(i_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvld(o_if_rvld), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvld(o_ls_rvld), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err), .o_busy(o_busy)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Memory responder: ack mem_lat+1 cycles after o_mem_req is first seen.
  always @(posedge clk) begin
    i_mem_ack <= 1'b0;
    if (o_mem_req && !i_mem_ack && !mem_never) begin
      if (mem_cnt == mem_lat) begin
        i_mem_ack   <= 1'b1;
        i_mem_rdata <= mem_data;
        mem_cnt     <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every grant and every response against the queues.
  always @(negedge clk) begin : monitor
    logic        g;
    logic [33:0] e;
    if (o_if_gnt || o_ls_gnt) begin
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_gnt", {30'd0, o_ls_gnt, o_if_gnt}, 32'd0);
      end else begin
        g = exp_gnt_q.pop_front();
        check("gnt_owner", {30'd0, o_ls_gnt, o_if_gnt}, g ? 32'd2 : 32'd1);
      end
    end
    if (o_if_rvld || o_ls_rvld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvld", {30'd0, o_ls_rvld, o_if_rvld}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvld_owner", {30'd0, o_ls_rvld, o_if_rvld}, e[33] ? 32'd2 : 32'd1);
        check("rvld_err", 32'(o_err), 32'(e[32]));
        check("rvld_rdata", o_ls_rvld ? o_ls_rdata : o_if_rdata, e[31:0]);
      end
    end else if (o_err) begin
      check("err_without_rvld", 32'(o_err), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_mem_req"}, 32'(o_mem_req), 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_misc"}, {22'd0, o_mem_bmask, o_mem_wren, o_if_gnt, o_ls_gnt,
                           o_if_rvld, o_ls_rvld, o_err}, 32'd0);
    check({tag, "_rdata"}, o_if_rdata | o_ls_rdata, 32'd0);
  endtask

  // Wait for all expected traffic to complete and the arbiter to idle.
  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 600; k++) begin
      tick();
      if (exp_q.size() == 0 && exp_gnt_q.size() == 0 && !o_busy) break;
    end
    if (k == 600) begin
      bad++;
      $display("FAIL %s_drain: got=pending want=idle", tag);
    end
  endtask

  initial begin
    int n;
    logic ok;
    i_reset = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_flush = 1'b0;
    i_ls_req = 1'b0; i_ls_wren = 1'b0; i_ls_addr = '0; i_ls_wdata = '0;
    i_ls_bmask = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    mem_lat = 0; mem_never = 1'b0; mem_data = '0; mem_cnt = 0;

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    i_reset = 1'b1;
    tick();

    // Zero-wait LS load.
    mem_data = 32'hDEAD_BEEF;
    exp_gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
    i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h0000_0040;
    i_ls_bmask = 4'hF;
    tick();
    check("load_gnt_c1", 32'(o_ls_gnt), 32'd1);
    check("load_req_c1", 32'(o_mem_req), 32'd1);
    check("load_addr", o_mem_addr, 32'h0000_0040);
    check("load_wren_bmask", {27'd0, o_mem_wren, o_mem_bmask}, 32'h0000_000F);
    i_ls_req = 1'b0;
    tick();
    check("load_req_c2", 32'(o_mem_req), 32'd1);
    tick();
    check("load_rvld_c3", 32'(o_ls_rvld), 32'd1);
    check("load_req_c3", 32'(o_mem_req), 32'd0);
    drain("load");

    // Both requesters held: LS x4 then IF, twice.
    mem_data = 32'h1234_5678;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 5; j++) begin
        exp_gnt_q.push_back(j != 4);
        exp_q.push_back({(j != 4), 1'b0, 32'h1234_5678});
      end
    end
    i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h0000_0080;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0200;
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      tick();
      if (o_if_gnt || o_ls_gnt) n++;
    end
    i_ls_req = 1'b0; i_if_req = 1'b0;
    check("starve_grant_count", n, 32'd10);
    drain("starve");

    // IF fetch flushed while waiting on slow memory.
    mem_lat = 4;
    exp_gnt_q.push_back(1'b0);
    i_if_req = 1'b1; i_if_addr = 32'h0000_0100;
    tick();
    check("flush_if_gnt", 32'(o_if_gnt), 32'd1);
    check("flush_if_fields", o_mem_addr, 32'h0000_0100);
    check("flush_if_bmask", {27'd0, o_mem_wren, o_mem_bmask}, 32'h0000_000F);
    i_if_req = 1'b0;
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("drop_req_held", 32'(o_mem_req), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (i_mem_ack) begin ok = 1'b1; break; end
      check("drop_busy_before_ack", 32'(o_busy), 32'd1);
      tick();
    end
    check("drop_ack_seen", 32'(ok), 32'd1);
    tick();
    check("drop_busy_after_ack", 32'(o_busy), 32'd0);
    check("drop_no_rvld", {30'd0, o_if_rvld, o_err}, 32'd0);
    mem_lat = 0; mem_data = 32'hCAFE_F00D;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
    i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
    tick();
    check("after_drop_gnt", 32'(o_if_gnt), 32'd1);
    i_if_req = 1'b0;
    drain("flush");

    // LS store that the memory never acknowledges.
    mem_never = 1'b1;
    exp_gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b1, 32'd0});
    i_ls_req = 1'b1; i_ls_wren = 1'b1; i_ls_addr = 32'h0000_0300;
    i_ls_wdata = 32'h55AA_33CC; i_ls_bmask = 4'b0011;
    tick();
    check("timeout_gnt", 32'(o_ls_gnt), 32'd1);
    i_ls_req = 1'b0;
    n = 0; ok = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!o_mem_req) break;
      n++;
      if (o_mem_bmask !== 4'b0011 || o_mem_wren !== 1'b1 || o_mem_wdata !== 32'h55AA_33CC) ok = 1'b0;
      tick();
    end
    check("timeout_req_cycles", n, MAX_WAIT + 1);
    check("timeout_fields_stable", 32'(ok), 32'd1);
    check("timeout_rvld_err", {30'd0, o_ls_rvld, o_err}, 32'd3);
    check("timeout_rdata", o_ls_rdata, 32'd0);
    mem_never = 1'b0;
    drain("timeout");

    // Reset during LS_WAIT abandons the access.
    mem_never = 1'b1;
    exp_gnt_q.push_back(1'b1);
    i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h0000_0500; i_ls_bmask = 4'hF;
    tick();
    check("rst_ls_gnt", 32'(o_ls_gnt), 32'd1);
    i_ls_req = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    check_all_zero("midrst");
    i_reset = 1'b1; mem_never = 1'b0; mem_data = 32'h0BAD_F00D;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    i_if_req = 1'b1; i_if_addr = 32'h0000_0600;
    tick();
    check("post_rst_if_gnt", 32'(o_if_gnt), 32'd1);
    check("post_rst_addr", o_mem_addr, 32'h0000_0600);
    i_if_req = 1'b0;
    drain("reset");

    // Flush in IDLE blocks the IF grant for that cycle only.
    mem_data = 32'h0000_7777;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_7777});
    i_if_req = 1'b1; i_if_addr = 32'h0000_0700; i_flush = 1'b1;
    tick();
    check("idle_flush_no_gnt", {30'd0, o_if_gnt, o_busy}, 32'd0);
    i_flush = 1'b0;
    tick();
    check("idle_flush_gnt_next", 32'(o_if_gnt), 32'd1);
    i_if_req = 1'b0;
    drain("idle_flush");

    // Flush coinciding with ack in IF_WAIT drops the response.
    mem_lat = 1; mem_data = 32'h0000_9999;
    exp_gnt_q.push_back(1'b0);
    i_if_req = 1'b1; i_if_addr = 32'h0000_0800;
    tick();
    check("ackflush_gnt", 32'(o_if_gnt), 32'd1);
    i_if_req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (i_mem_ack) begin ok = 1'b1; break; end
    end
    check("ackflush_ack_seen", 32'(ok), 32'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("ackflush_idle", {29'd0, o_busy, o_mem_req, o_if_rvld}, 32'd0);
    drain("ackflush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF, read-only) and load/store (LS, read/write) in the pipelined RV32I core.
- LS has priority by default; a starvation counter periodically promotes IF.
- Handles variable-latency memory through a req/ack handshake, with a wait watchdog and IF flush-drop on branch/jump redirect (driven by o_ctrl from decode).

Parameters:
- MAX_WAIT, 255, cycles o_mem_req may stay high without i_mem_ack before timeout.
- STARVE_LIM, 4, consecutive LS grants with IF pending before IF is forced to win.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-low reset
- i_if_req  in  1  IF read request; held stable until o_if_gnt
- i_if_addr  in  32  IF word address
- i_flush  in  1  redirect: cancel in-flight IF response
- o_if_gnt  out  1  one-cycle grant pulse
- o_if_rvld  out  1  one-cycle response valid
- o_if_rdata  out  32  fetched instruction
- i_ls_req  in  1  LS request; held stable until o_ls_gnt
- i_ls_wren  in  1  1 = store, 0 = load
- i_ls_addr  in  32  LS address
- i_ls_wdata  in  32  store data
- i_ls_bmask  in  4  store byte mask
- o_ls_gnt  out  1  one-cycle grant pulse
- o_ls_rvld  out  1  one-cycle load data valid / store done
- o_ls_rdata  out  32  load data
- o_mem_req  out  1  memory request, held until ack
- o_mem_wren  out  1  write strobe qualifier
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  write data
- o_mem_bmask  out  4  byte mask (4'hF for reads)
- i_mem_ack  in  1  memory completion; i_mem_rdata valid with it
- i_mem_rdata  in  32  read data
- o_err  out  1  one-cycle timeout flag, coincident with rvld
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (i_reset=0 at a clk edge): state IDLE; all outputs 0; wait_cnt=0; starve_cnt=0. Reset mid-transaction abandons it; no rvld is produced.
- All outputs are registered.
- States: IDLE, IF_WAIT, LS_WAIT, IF_DROP.
- IDLE arbitration at each edge:
  - LS wins if i_ls_req, unless i_if_req && starve_cnt==STARVE_LIM, in which case IF wins.
  - IF is eligible only if i_if_req && !i_flush.
  - On a win: latch the requester's fields onto the o_mem_* outputs, set o_mem_req=1, pulse the matching gnt for exactly one cycle, and clear wait_cnt.
  - IF fields: o_mem_wren=0, o_mem_bmask=4'hF, o_mem_wdata=0.
- starve_cnt:
  - +1 (saturating at STARVE_LIM) on an LS grant while i_if_req=1.
  - Cleared on an IF grant.
  - Unchanged otherwise.
- X_WAIT (IF_WAIT or LS_WAIT):
  - wait_cnt increments each cycle without ack.
  - On i_mem_ack: o_mem_req goes to 0 and the owner's rvld pulses for one cycle next cycle.
  - On that ack: rdata captures i_mem_rdata (LS store: o_ls_rdata=0) and the state returns to IDLE.
- Latency:
  - Grant occurs 1 cycle after request.
  - rvld occurs 1 cycle after ack.
  - Minimum 3 cycles request-to-rvld with zero-wait memory.
  - One IDLE cycle always separates transactions.
- Timeout: if wait_cnt==MAX_WAIT with no ack, then:
  - o_mem_req goes to 0.
  - The owner's rvld pulses with rdata=0 and o_err=1.
  - The state returns to IDLE.
- Flush:
  - i_flush in IF_WAIT moves the state to IF_DROP; o_mem_req stays high.
  - IF_DROP: on ack or timeout, return to IDLE with no o_if_rvld and no o_err.
  - i_flush in LS_WAIT or IF_DROP has no effect.
  - i_flush in IDLE blocks an IF grant that cycle only.
- Simultaneous ack and flush in IF_WAIT: flush wins, so the response is dropped.
- i_mem_ack while IDLE is ignored.
- Address and data are passed through unmodified; no alignment checking is done here.

Decomposition:
- package_param additions:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_IF_WAIT, ARB_LS_WAIT, ARB_IF_DROP}.
  - Constants ARB_MAX_WAIT_DEF=255 and ARB_STARVE_LIM_DEF=4.
- Sub-module arb_wait_timer:
  - Parameterised counter, width $clog2(MAX_WAIT+1).
  - Inputs: clear and enable. Output: expired.
  - Shared by the watchdog; starve_cnt stays inline.

Test Plan:
- Zero-wait memory (ack the cycle after o_mem_req). LS load 0x0000_0040 with the memory returning 0xDEAD_BEEF -> o_ls_gnt at cycle 1, o_mem_req at cycles 1-2, o_ls_rvld=1 with o_ls_rdata=0xDEAD_BEEF at cycle 3, o_err=0.
- i_if_req and i_ls_req held continuously -> grant order LS,LS,LS,LS,IF,LS,...; an IF grant occurs after every 4 LS grants.
- IF fetch at 0x100 with memory latency 5, i_flush pulsed at cycle 2 -> no o_if_rvld; o_busy drops after ack; next IF request is granted normally.
- Memory never acks an LS store with bmask 4'b0011 -> o_mem_bmask=4'b0011 throughout; after 255 wait cycles o_ls_rvld=1, o_err=1, o_ls_rdata=0; returns to IDLE.
- i_reset=0 asserted during LS_WAIT -> next cycle all outputs 0, no rvld; after release an IF request is granted in 1 cycle.
- i_flush and i_if_req in the same IDLE cycle with no LS request -> no grant that cycle; grant the following cycle.
